// File: rtl/text_grid_buffer_pkg.sv
// Shared constants and types for the character-cell text buffer.
// Control codes arrive on the same bus as printable characters.
package text_grid_buffer_pkg;

  localparam logic [7:0] CC_NEWLINE   = 8'h0D;
  localparam logic [7:0] CC_BACKSPACE = 8'h08;
  localparam logic [7:0] CC_CLEAR     = 8'h0C;

  localparam logic [6:0] BLANK_DEFAULT = 7'h20;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CLEAR
  } grid_state_t;

  function automatic int cell_count(input int cols, input int rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/text_grid_store.sv
// Cell array: one write port, a registered display read port (1-cycle latency)
// and a combinational sweep-source read port; async reset fills every cell with BLANK.
module text_grid_store
  import text_grid_buffer_pkg::*;
#(
  parameter int              NUM_CELLS = 50,
  parameter int              IDX_W     = 6,
  parameter int              CHAR_W    = 7,
  parameter logic [CHAR_W-1:0] BLANK   = CHAR_W'(BLANK_DEFAULT)
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [CHAR_W-1:0] wr_dat,
  input  logic              rd_ok,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [CHAR_W-1:0] rd_char,
  input  logic [IDX_W-1:0]  src_addr,
  output logic [CHAR_W-1:0] src_dat
);

  logic [CHAR_W-1:0] cells [NUM_CELLS];

  // Display read samples the array before this edge's write lands.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells[i] <= BLANK;
      end
      rd_char <= BLANK;
    end else begin
      if (wr_en) begin
        cells[wr_addr] <= wr_dat;
      end
      rd_char <= rd_ok ? cells[rd_addr] : BLANK;
    end
  end

  assign src_dat = (int'(src_addr) < NUM_CELLS) ? cells[src_addr] : BLANK;

endmodule

// File: rtl/text_grid_buffer.sv
// Text grid with cursor, backspace/newline/clear and scroll-on-overflow.
// Scroll and clear sweep one cell per cycle; strobes seen while busy are dropped and flagged.
module text_grid_buffer
  import text_grid_buffer_pkg::*;
#(
  parameter int                GRID_COL  = 10,
  parameter int                GRID_ROW  = 5,
  parameter int                CHAR_W    = 7,
  parameter bit                SCROLL_EN = 1'b1,
  parameter logic [CHAR_W-1:0] BLANK     = CHAR_W'(BLANK_DEFAULT)
) (
  input  logic                        clk_pix,
  input  logic                        rst_pix,
  input  logic [CHAR_W-1:0]           ascii_in,
  input  logic                        write_en,
  input  logic                        ctrl_en,
  input  logic [$clog2(GRID_COL)-1:0] rd_col,
  input  logic [$clog2(GRID_ROW)-1:0] rd_row,
  output logic [CHAR_W-1:0]           rd_char,
  output logic [$clog2(GRID_COL)-1:0] cursor_col,
  output logic [$clog2(GRID_ROW)-1:0] cursor_row,
  output logic                        busy,
  output logic                        drop_flag
);

  localparam int COL_W     = $clog2(GRID_COL);
  localparam int ROW_W     = $clog2(GRID_ROW);
  localparam int NUM_CELLS = cell_count(GRID_COL, GRID_ROW);
  localparam int IDX_W     = $clog2(NUM_CELLS);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(GRID_COL - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(GRID_ROW - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CELLS - 1);
  localparam logic [CHAR_W-1:0] NL_CODE  = CHAR_W'(CC_NEWLINE);
  localparam logic [CHAR_W-1:0] BS_CODE  = CHAR_W'(CC_BACKSPACE);
  localparam logic [CHAR_W-1:0] CLR_CODE = CHAR_W'(CC_CLEAR);

  grid_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              drop_q, drop_d;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [CHAR_W-1:0] wr_dat;
  logic              adv;
  logic [IDX_W-1:0]  cur_idx;
  logic              rd_ok;
  logic [IDX_W-1:0]  rd_addr;
  logic [IDX_W-1:0]  src_addr;
  logic [CHAR_W-1:0] src_dat;
  logic              sweep_copy;

  assign cur_idx = IDX_W'(int'(row_q) * GRID_COL + int'(col_q));
  assign rd_ok   = (int'(rd_col) < GRID_COL) && (int'(rd_row) < GRID_ROW);
  assign rd_addr = rd_ok ? IDX_W'(int'(rd_row) * GRID_COL + int'(rd_col)) : '0;

  // Scroll pulls each cell from one row below; the last row has no source and fills BLANK.
  assign sweep_copy = (int'(idx_q) < NUM_CELLS - GRID_COL);
  assign src_addr   = sweep_copy ? IDX_W'(int'(idx_q) + GRID_COL) : '0;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q <= IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    drop_d  = drop_q;
    wr_en   = 1'b0;
    wr_addr = cur_idx;
    wr_dat  = BLANK;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_en) begin
          if (ascii_in == NL_CODE) begin
            col_d = '0;
            adv   = 1'b1;
          end else if (ascii_in == BS_CODE) begin
            // Either predecessor (same row or end of previous row) is cur_idx-1.
            if (col_q != '0) begin
              col_d   = col_q - COL_W'(1);
              wr_en   = 1'b1;
              wr_addr = cur_idx - IDX_W'(1);
            end else if (row_q != '0) begin
              row_d   = row_q - ROW_W'(1);
              col_d   = COL_LAST;
              wr_en   = 1'b1;
              wr_addr = cur_idx - IDX_W'(1);
            end
          end else if (ascii_in == CLR_CODE) begin
            col_d   = '0;
            row_d   = '0;
            drop_d  = 1'b0;
            idx_d   = '0;
            state_d = CLEAR;
          end
        end else if (write_en) begin
          wr_en  = 1'b1;
          wr_dat = ascii_in;
          if (col_q < COL_LAST) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d = '0;
            adv   = 1'b1;
          end
        end

        if (adv) begin
          if (row_q < ROW_LAST) begin
            row_d = row_q + ROW_W'(1);
          end else if (SCROLL_EN) begin
            idx_d   = '0;
            state_d = SCROLL;
          end else begin
            row_d = '0;
          end
        end
      end

      SCROLL, CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_dat  = (state_q == SCROLL && sweep_copy) ? src_dat : BLANK;
        if (write_en || ctrl_en) begin
          drop_d = 1'b1;
        end
        // Counter holds at the last cell rather than wrapping.
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  text_grid_store #(
    .NUM_CELLS (NUM_CELLS),
    .IDX_W     (IDX_W),
    .CHAR_W    (CHAR_W),
    .BLANK     (BLANK)
  ) u_store (
    .clk_pix  (clk_pix),
    .rst_pix  (rst_pix),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_dat   (wr_dat),
    .rd_ok    (rd_ok),
    .rd_addr  (rd_addr),
    .rd_char  (rd_char),
    .src_addr (src_addr),
    .src_dat  (src_dat)
  );

  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = (state_q != IDLE);
  assign drop_flag  = drop_q;

endmodule
